// File: rtl/loop_replay_reader_pkg.sv
// Shared definitions for the loop micro-op buffer: replay state encoding,
// RISC-V control-flow opcodes used by the capture side, and default geometry.
package loop_replay_reader_pkg;

  localparam int DEFAULT_ADDR_W = 3;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] STREAM_ENC = 2'd1;
  localparam logic [1:0] ABORT_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE_ENC,
    ST_STREAM = STREAM_ENC,
    ST_ABORT  = ABORT_ENC
  } replay_state_e;

  localparam logic [6:0] JAL_OPCODE   = 7'b1101111;
  localparam logic [6:0] BTYPE_OPCODE = 7'b1100011;

endpackage

// File: rtl/loop_replay_reader_skid_fifo.sv
// Two-entry output FIFO holding {pc, instruction} pairs between the uop cache
// read port and decode; clear wins over same-cycle push/pop.
module replay_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q[gi] <= '0;
        end else if (do_push && !clear_i && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      if (do_push && !do_pop)      count_q <= count_q + 2'd1;
      else if (do_pop && !do_push) count_q <= count_q - 2'd1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/loop_replay_reader.sv
// Replays a captured loop body from the uop cache to decode, wrapping at the
// loop end, counting iterations and aborting with a flush on mispredict.
module loop_replay_reader
  import loop_replay_reader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int XLEN   = 32,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   loop_len,
  input  logic [XLEN-1:0]   loop_start_pc,
  input  logic              mispredict,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instruction,
  output logic [XLEN-1:0]   out_pc,
  output logic              block_signal,
  output logic              flush,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  replay_state_e     state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [XLEN-1:0]   base_pc_q;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [ADDR_W-1:0] infl_idx_q;
  logic              infl_q;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic              start_ok;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        fifo_cnt;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [2:0]        occupancy;

  assign len_m1   = len_q - 1'b1;
  assign last_idx = len_m1[ADDR_W-1:0];
  assign start_ok = (state_q == ST_IDLE) && start && !mispredict &&
                    (loop_len != '0) && (loop_len <= MAX_LEN);

  // Credit counts entries that will still occupy the FIFO after this cycle's pop,
  // which keeps full throughput with a 2-entry FIFO and 1-cycle read latency.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, fifo_pop};

  always_comb begin
    state_d      = state_q;
    rd_en        = 1'b0;
    block_signal = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        block_signal = 1'b1;
        if (mispredict) state_d = ST_ABORT;
        else if (occupancy < 3'd2) rd_en = 1'b1;
      end
      ST_ABORT: begin
        flush   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_STREAM) && (fifo_cnt != 2'd0);
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = (state_q == ST_STREAM) && infl_q && !mispredict;
  assign fifo_clear = start_ok || (state_q == ST_ABORT) ||
                      ((state_q == ST_STREAM) && mispredict);

  always_comb begin
    rd_idx_d  = rd_idx_q;
    out_idx_d = out_idx_q;
    iter_d    = iter_q;
    if (start_ok) begin
      rd_idx_d  = '0;
      out_idx_d = '0;
      iter_d    = '0;
    end else begin
      if (rd_en) rd_idx_d = (rd_idx_q == last_idx) ? '0 : rd_idx_q + 1'b1;
      if (fifo_pop) begin
        out_idx_d = (out_idx_q == last_idx) ? '0 : out_idx_q + 1'b1;
        if ((out_idx_q == last_idx) && (iter_q != '1)) iter_d = iter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      base_pc_q  <= '0;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      infl_idx_q <= '0;
      infl_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      out_idx_q <= out_idx_d;
      iter_q    <= iter_d;
      infl_q    <= rd_en;
      if (rd_en) infl_idx_q <= rd_idx_q;
      if (start_ok) begin
        len_q     <= loop_len;
        base_pc_q <= loop_start_pc;
      end
    end
  end

  replay_skid_fifo #(.W(2 * XLEN)) u_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  ({base_pc_q + XLEN'({infl_idx_q, 2'b00}), rd_data}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign rd_addr         = (state_q == ST_STREAM) ? rd_idx_q : '0;
  assign out_instruction = out_valid ? fifo_head[XLEN-1:0] : '0;
  assign out_pc          = out_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
  assign iter_count      = iter_q;

endmodule
